wb_port_arbiter: RTL and testbench

//  Shares the ROB's WB_WIDTH writeback ports among NUM_FU functional-unit completion requesters.

---
 rtl/wb_port_arbiter.sv | 101 ++++++++++
 tb/tb_wb_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that packs up to WB_WIDTH FU completions per cycle onto the ROB writeback ports.
// Grants are combinational; the selected payloads are registered onto wb_*_o one cycle later.
module wb_port_arbiter #(
  parameter int NUM_FU   = 6,
  parameter int WB_WIDTH = 4,
  parameter int DEPTH    = 64,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int PTR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W   = $clog2(WB_WIDTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_FU-1:0]                  fu_valid_i,
  input  logic [NUM_FU-1:0][IDX_W-1:0]       fu_rob_idx_i,
  input  logic [NUM_FU-1:0]                  fu_exception_i,
  input  logic [NUM_FU-1:0]                  fu_mispred_i,
  output logic [NUM_FU-1:0]                  fu_ready_o,
  input  logic                               flush_i,
  output logic [WB_WIDTH-1:0]                wb_valid_o,
  output logic [WB_WIDTH-1:0][IDX_W-1:0]     wb_rob_idx_o,
  output logic [WB_WIDTH-1:0]                wb_exception_o,
  output logic [WB_WIDTH-1:0]                wb_mispred_o
);

  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                rr_next_p0;
  logic [PTR_W-1:0]                last_fu_p0;
  logic [NUM_FU-1:0]               grant_p0;
  logic [WB_WIDTH-1:0]             port_vld_p0;
  logic [WB_WIDTH-1:0]             port_exc_p0;
  logic [WB_WIDTH-1:0]             port_mis_p0;
  logic [WB_WIDTH-1:0][IDX_W-1:0]  port_idx_p0;

  // Stage p0: rotate-scan from rr_ptr, granting valid FUs into the next free port
  always_comb begin : scan
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] fu;
    logic [CNT_W-1:0] cnt;
    logic             flag_used;
    logic             flagged;
    sum         = '0;
    fu          = '0;
    cnt         = '0;
    flag_used   = 1'b0;
    flagged     = 1'b0;
    grant_p0    = '0;
    port_vld_p0 = '0;
    port_exc_p0 = '0;
    port_mis_p0 = '0;
    port_idx_p0 = '0;
    last_fu_p0  = rr_ptr;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
      fu      = sum[PTR_W-1:0];
      flagged = fu_exception_i[fu] | fu_mispred_i[fu];
      // A second flagged requester is passed over without using up a port
      if (fu_valid_i[fu] && (cnt < CNT_W'(WB_WIDTH)) && !(flagged && flag_used)) begin
        grant_p0[fu] = 1'b1;
        for (int p = 0; p < WB_WIDTH; p++) begin
          if (cnt == CNT_W'(p)) begin
            port_vld_p0[p] = 1'b1;
            port_idx_p0[p] = fu_rob_idx_i[fu];
            port_exc_p0[p] = fu_exception_i[fu];
            port_mis_p0[p] = fu_mispred_i[fu];
          end
        end
        flag_used  = flag_used | flagged;
        last_fu_p0 = fu;
        cnt        = cnt + CNT_W'(1);
      end
    end
  end

  assign rr_next_p0 = (last_fu_p0 == PTR_W'(NUM_FU - 1)) ? '0 : last_fu_p0 + PTR_W'(1);
  assign fu_ready_o = (reset_n && !flush_i) ? grant_p0 : '0;

  // Stage p1: register winners onto the ROB writeback ports
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr         <= '0;
      wb_valid_o     <= '0;
      wb_rob_idx_o   <= '0;
      wb_exception_o <= '0;
      wb_mispred_o   <= '0;
    end else if (flush_i) begin
      wb_valid_o <= '0;
    end else begin
      wb_valid_o <= port_vld_p0;
      for (int p = 0; p < WB_WIDTH; p++) begin
        if (port_vld_p0[p]) begin
          wb_rob_idx_o[p]   <= port_idx_p0[p];
          wb_exception_o[p] <= port_exc_p0[p];
          wb_mispred_o[p]   <= port_mis_p0[p];
        end
      end
      if (|grant_p0) rr_ptr <= rr_next_p0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_port_arbiter;
  localparam int NUM_FU = 6, WB_WIDTH = 4, DEPTH = 64, IW = $clog2(DEPTH);

  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic [NUM_FU-1:0]            fu_valid = '0, fu_exc = '0, fu_mis = '0, fu_ready;
  logic [NUM_FU-1:0][IW-1:0]    fu_idx = '0;
  logic [WB_WIDTH-1:0]          wb_valid, wb_exc, wb_mis;
  logic [WB_WIDTH-1:0][IW-1:0]  wb_idx;

  wb_port_arbiter #(.NUM_FU(NUM_FU), .WB_WIDTH(WB_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .fu_valid_i(fu_valid), .fu_rob_idx_i(fu_idx),
    .fu_exception_i(fu_exc), .fu_mispred_i(fu_mis), .fu_ready_o(fu_ready), .flush_i(flush),
    .wb_valid_o(wb_valid), .wb_rob_idx_o(wb_idx), .wb_exception_o(wb_exc), .wb_mispred_o(wb_mis));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Reference model: round-robin pointer, list of winners this cycle, expected output registers
  int                          m_rr;
  int                          gnt[$];
  logic [NUM_FU-1:0]           exp_rdy;
  logic [WB_WIDTH-1:0]         m_vld, m_exc, m_mis;
  logic [WB_WIDTH-1:0][IW-1:0] m_idx;

  function automatic void model_reset();
    m_rr = 0; m_vld = '0; m_exc = '0; m_mis = '0; m_idx = '0; gnt.delete(); exp_rdy = '0;
  endfunction

  function automatic void model_pick();
    bit taken;
    taken = 1'b0; gnt.delete(); exp_rdy = '0;
    if (!reset_n || flush) return;
    for (int k = 0; k < NUM_FU && gnt.size() < WB_WIDTH; k++) begin
      int f;
      f = (m_rr + k) % NUM_FU;
      if (fu_valid[f] && !((fu_exc[f] | fu_mis[f]) && taken)) begin
        gnt.push_back(f);
        exp_rdy[f] = 1'b1;
        taken = taken | fu_exc[f] | fu_mis[f];
      end
    end
  endfunction

  function automatic void model_commit();
    m_vld = '0;
    if (flush) return;
    foreach (gnt[p]) begin
      m_vld[p] = 1'b1; m_idx[p] = fu_idx[gnt[p]];
      m_exc[p] = fu_exc[gnt[p]]; m_mis[p] = fu_mis[gnt[p]];
    end
    if (gnt.size() > 0) m_rr = (gnt[gnt.size()-1] + 1) % NUM_FU;
  endfunction

  task automatic settle();
    #1; model_pick();
  endtask

  task automatic tick();
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; fu_valid = '0; fu_exc = '0; fu_mis = '0; flush = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1; model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    fu_valid = '1;
    for (int i = 0; i < NUM_FU; i++) fu_idx[i] = IW'(10 + i);
    #1;
    n_checks++; if (fu_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", fu_ready); end
    n_checks++; if (wb_valid !== '0) begin n_fail++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
    @(negedge clk); reset_n = 1'b1; model_reset(); settle();
    n_checks++; if (fu_ready !== 6'b001111) begin n_fail++; $display("FAIL reset_first_grant got=%b want=001111", fu_ready); end
    tick();
    n_checks++; if ({wb_valid, wb_idx, wb_exc, wb_mis} !== {m_vld, m_idx, m_exc, m_mis}) begin
      n_fail++; $display("FAIL reset_first_wb got=%b/%h want=%b/%h", wb_valid, wb_idx, m_vld, m_idx); end
  endtask

  task automatic test_single();
    @(negedge clk); fu_valid = 6'b000100; fu_idx[2] = IW'(9); settle();
    n_checks++; if (fu_ready !== 6'b000100) begin n_fail++; $display("FAIL single_ready got=%b want=000100", fu_ready); end
    tick();
    n_checks++; if (wb_valid !== 4'b0001 || wb_idx[0] !== IW'(9)) begin
      n_fail++; $display("FAIL single_wb got=%b idx=%0d want=0001 idx=9", wb_valid, wb_idx[0]); end
    @(negedge clk); fu_valid = '0;
  endtask

  task automatic test_oversub();
    logic [NUM_FU-1:0] want [3];
    want[0] = 6'b001111; want[1] = 6'b110011; want[2] = 6'b111100;
    do_reset();
    fu_valid = '1;
    for (int i = 0; i < NUM_FU; i++) fu_idx[i] = IW'(20 + i);
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++; if (fu_ready !== want[c]) begin n_fail++; $display("FAIL oversub_ready c=%0d got=%b want=%b", c, fu_ready, want[c]); end
      tick();
      n_checks++; if ({wb_valid, wb_idx, wb_exc, wb_mis} !== {m_vld, m_idx, m_exc, m_mis}) begin
        n_fail++; $display("FAIL oversub_wb c=%0d got=%b/%h want=%b/%h", c, wb_valid, wb_idx, m_vld, m_idx); end
      @(negedge clk);
    end
    n_checks++; if (wb_idx[0] !== IW'(22) || wb_idx[3] !== IW'(25)) begin
      n_fail++; $display("FAIL oversub_pack got p0=%0d p3=%0d want p0=22 p3=25", wb_idx[0], wb_idx[3]); end
    fu_valid = '0;
  endtask

  task automatic test_flag_rule();
    do_reset();
    fu_valid = 6'b001111; fu_mis = 6'b000010; fu_exc = 6'b000100;
    fu_idx[0] = IW'(2); fu_idx[1] = IW'(3); fu_idx[2] = IW'(4); fu_idx[3] = IW'(5);
    settle();
    n_checks++; if (fu_ready !== 6'b001011) begin n_fail++; $display("FAIL flag_ready got=%b want=001011", fu_ready); end
    tick();
    n_checks++; if (wb_valid !== 4'b0111 || wb_mis !== 4'b0010 || wb_idx[2] !== IW'(5)) begin
      n_fail++; $display("FAIL flag_wb got v=%b mis=%b p2=%0d want v=0111 mis=0010 p2=5", wb_valid, wb_mis, wb_idx[2]); end
    @(negedge clk); fu_valid = 6'b000100; fu_mis = '0; settle();
    n_checks++; if (fu_ready !== 6'b000100) begin n_fail++; $display("FAIL flag_retry_ready got=%b want=000100", fu_ready); end
    tick();
    n_checks++; if (wb_valid !== 4'b0001 || wb_exc[0] !== 1'b1 || wb_idx[0] !== IW'(4)) begin
      n_fail++; $display("FAIL flag_retry_wb got v=%b exc=%b want v=0001 exc[0]=1", wb_valid, wb_exc); end
    @(negedge clk); fu_valid = '0; fu_exc = '0;
  endtask

  task automatic test_flush();
    // Pointer is 3 here; flush must leave it there
    fu_valid = 6'b001111;
    for (int i = 0; i < 4; i++) fu_idx[i] = IW'(40 + i);
    flush = 1'b1; settle();
    n_checks++; if (fu_ready !== '0) begin n_fail++; $display("FAIL flush_ready got=%b want=0", fu_ready); end
    tick();
    n_checks++; if (wb_valid !== '0) begin n_fail++; $display("FAIL flush_wb got=%b want=0", wb_valid); end
    @(negedge clk); flush = 1'b0; settle();
    n_checks++; if (fu_ready !== 6'b001111) begin n_fail++; $display("FAIL flush_regrant got=%b want=001111", fu_ready); end
    tick();
    n_checks++; if (wb_valid !== 4'b1111 || wb_idx[0] !== IW'(43) || wb_idx[1] !== IW'(40)) begin
      n_fail++; $display("FAIL flush_order got v=%b p0=%0d p1=%0d want 1111 43 40", wb_valid, wb_idx[0], wb_idx[1]); end
    @(negedge clk); fu_valid = '0;
  endtask

  task automatic test_wrap();
    fu_valid = 6'b010000; settle(); tick();
    @(negedge clk); fu_valid = 6'b100001; fu_idx[5] = IW'(55); fu_idx[0] = IW'(50); settle();
    n_checks++; if (fu_ready !== 6'b100001) begin n_fail++; $display("FAIL wrap_ready got=%b want=100001", fu_ready); end
    tick();
    n_checks++; if (wb_valid !== 4'b0011 || wb_idx[0] !== IW'(55) || wb_idx[1] !== IW'(50)) begin
      n_fail++; $display("FAIL wrap_wb got v=%b p0=%0d p1=%0d want 0011 55 50", wb_valid, wb_idx[0], wb_idx[1]); end
    @(negedge clk); fu_valid = '1; settle();
    n_checks++; if (fu_ready !== 6'b011110) begin n_fail++; $display("FAIL wrap_ptr got=%b want=011110", fu_ready); end
    tick();
    @(negedge clk); fu_valid = '0;
  endtask

  task automatic test_async_reset();
    fu_valid = 6'b000011; settle(); tick();
    @(negedge clk); reset_n = 1'b0; #1;
    n_checks++; if (wb_valid !== '0 || fu_ready !== '0 || wb_idx !== '0) begin
      n_fail++; $display("FAIL async_reset got v=%b rdy=%b idx=%h want all 0", wb_valid, fu_ready, wb_idx); end
    @(negedge clk); reset_n = 1'b1; model_reset(); fu_valid = '0;
  endtask

  task automatic test_random();
    logic [NUM_FU-1:0] granted;
    granted = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      flush = ($urandom_range(0, 7) == 0);
      for (int f = 0; f < NUM_FU; f++) begin
        if (!fu_valid[f] || granted[f]) begin
          fu_valid[f] = $urandom_range(0, 3) != 0;
          fu_idx[f]   = IW'($urandom_range(0, DEPTH - 1));
          fu_exc[f]   = $urandom_range(0, 4) == 0;
          fu_mis[f]   = $urandom_range(0, 4) == 0;
        end
      end
      settle();
      n_checks++; if (fu_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, fu_ready, exp_rdy); end
      granted = exp_rdy;
      tick();
      n_checks++; if ({wb_valid, wb_idx, wb_exc, wb_mis} !== {m_vld, m_idx, m_exc, m_mis}) begin
        n_fail++; $display("FAIL rand_wb c=%0d got=%b/%h/%b/%b want=%b/%h/%b/%b", c,
                           wb_valid, wb_idx, wb_exc, wb_mis, m_vld, m_idx, m_exc, m_mis); end
    end
    @(negedge clk); flush = 1'b0; fu_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_oversub();
    test_flag_rule();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
